fir4_rr_sched: RTL and testbench



---
 rtl/fir4_sched_pkg.sv | 25 ++
 rtl/fir4_sum4.sv | 15 +
 rtl/fir4_rr_sched.sv | 150 +++++++++++++++
 tb/tb_fir4_rr_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir4_sched_pkg.sv
// Shared types for the time-multiplexed 4-tap FIR scheduler.
// Combinational helpers only; no latency.
// No flow control here; the pipeline stalls are handled in fir4_rr_sched.
package fir4_sched_pkg;

  localparam int DEF_W   = 16;
  localparam int DEF_NCH = 4;

  typedef logic signed [DEF_W-1:0] sample_t;
  typedef logic signed [DEF_W+1:0] acc_t;

  // Current sample plus the three previous ones, newest first
  typedef struct packed {
    sample_t x;
    sample_t h0;
    sample_t h1;
    sample_t h2;
  } taps_t;

  // Sign-extend one sample to the accumulator width
  function automatic acc_t sext_acc(input sample_t s);
    return acc_t'(s);
  endfunction

endpackage

// File: rtl/fir4_sum4.sv
// Signed 4-input adder for the FIR sum stage.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is captured.
module fir4_sum4
  import fir4_sched_pkg::*;
(
  input  taps_t taps,
  output acc_t  sum
);

  // Two guard bits make the four-way sum exact for any signed inputs
  assign sum = sext_acc(taps.x) + sext_acc(taps.h0)
             + sext_acc(taps.h1) + sext_acc(taps.h2);

endmodule

// File: rtl/fir4_rr_sched.sv
// Round-robin shared 4-tap FIR sum over NCH channels with per-channel tap history.
// Accept at edge k gives out_valid after edge k+1 (fires at edge k+2 with no stall).
// in_ready drops for all channels when both pipeline stages are full and out_ready is low.
module fir4_rr_sched
  import fir4_sched_pkg::*;
#(
  // Tap and result types come from the package, so W must stay equal to DEF_W
  parameter int  W   = DEF_W,
  parameter int  NCH = DEF_NCH,
  localparam int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [W+1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             out_ready
);

  // Per-channel history: index 0 is h0 (newest)
  sample_t       hist_q [NCH][3];
  sample_t       hist_d [NCH][3];
  logic [CW-1:0] ptr_q, ptr_d;
  logic          s1_v_q, s1_v_d;
  logic [CW-1:0] s1_ch_q, s1_ch_d;
  taps_t         s1_taps_q, s1_taps_d;
  logic          out_valid_q, out_valid_d;
  acc_t          out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;

  logic          found;
  logic [CW-1:0] grant;
  logic          s2_free, can_accept, s1_adv, out_fire, accept;
  sample_t       in_x;
  acc_t          sum;

  // Round-robin search: first requesting channel at or after ptr
  always_comb begin
    int            idx_i;
    logic [CW-1:0] idx;
    found = 1'b0;
    grant = '0;
    idx_i = 0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= NCH) idx_i = idx_i - NCH;
      idx = CW'(idx_i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign in_x = in_data[grant*W +: W];

  // Pipeline handshakes and the single-hot accept strobe
  always_comb begin
    out_fire   = out_valid_q && out_ready;
    s2_free    = !out_valid_q || out_ready;
    can_accept = !s1_v_q || s2_free;
    s1_adv     = s1_v_q && s2_free;
    accept     = found && can_accept && !flush && !reset;
    in_ready   = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  fir4_sum4 u_sum4 (
    .taps (s1_taps_q),
    .sum  (sum)
  );

  // Next state for history, pointer and both pipeline stages
  always_comb begin
    hist_d      = hist_q;
    ptr_d       = ptr_q;
    s1_v_d      = s1_v_q;
    s1_ch_d     = s1_ch_q;
    s1_taps_d   = s1_taps_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 3; t++) hist_d[c][t] = '0;
      end
    end else if (accept) begin
      hist_d[grant][2] = hist_q[grant][1];
      hist_d[grant][1] = hist_q[grant][0];
      hist_d[grant][0] = in_x;
    end

    // Stage 1 captures the pre-shift taps so back-to-back accepts chain correctly
    if (accept) begin
      ptr_d        = (grant == CW'(NCH-1)) ? '0 : grant + 1'b1;
      s1_v_d       = 1'b1;
      s1_ch_d      = grant;
      s1_taps_d.x  = in_x;
      s1_taps_d.h0 = hist_q[grant][0];
      s1_taps_d.h1 = hist_q[grant][1];
      s1_taps_d.h2 = hist_q[grant][2];
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = sum;
      out_ch_d    = s1_ch_q;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 3; t++) hist_q[c][t] <= '0;
      end
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_ch_q     <= '0;
      s1_taps_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      hist_q      <= hist_d;
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_ch_q     <= s1_ch_d;
      s1_taps_q   <= s1_taps_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fir4_rr_sched.sv
// Self-checking bench for fir4_rr_sched: directed scenarios plus random traffic.
// A transaction-level model predicts results, ordering, latency and in_ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fir4_rr_sched;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic [W+1:0]     out_data;
  logic [CW-1:0]    out_ch;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit strict_lat = 1'b0;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } item_t;

  item_t        exp_q[$];
  int           mhist [NCH][3];
  int           rr_ptr = 0;
  int           inflight = 0;
  int           last_out [NCH];
  bit           hold_pend = 1'b0;
  logic [W+1:0] hold_data;
  logic [CW-1:0] hold_ch;

  fir4_rr_sched #(.W(W), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference model: FIR as plain arithmetic over each channel's last four samples
  always @(negedge clk) begin
    logic [NCH-1:0] exp_rdy;
    int idx;
    int acc_ch;
    int x;
    item_t it;
    if (reset) begin
      chk("rdy_in_reset", int'(in_ready), 0);
      exp_q.delete();
      for (int c = 0; c < NCH; c++) for (int t = 0; t < 3; t++) mhist[c][t] = 0;
      rr_ptr = 0;
      inflight = 0;
      hold_pend = 1'b0;
    end else begin
      exp_rdy = '0;
      if (!flush && !(inflight == 2 && !out_ready)) begin
        for (int k = 0; k < NCH; k++) begin
          idx = (rr_ptr + k) % NCH;
          if (in_valid[idx]) begin
            exp_rdy[idx] = 1'b1;
            break;
          end
        end
      end
      chk("in_ready", int'(in_ready), int'(exp_rdy));

      if (hold_pend) begin
        chk("hold_data", int'(out_data), int'(hold_data));
        chk("hold_ch", int'(out_ch), int'(hold_ch));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_ch   = out_ch;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          it = exp_q.pop_front();
          chk("out_ch", int'(out_ch), it.ch);
          chk("out_data", int'($signed(out_data)), it.data);
          if (strict_lat) chk("latency", cyc - it.cyc, 2);
          inflight--;
        end
        last_out[out_ch] = int'($signed(out_data));
      end

      acc_ch = -1;
      for (int k = 0; k < NCH; k++)
        if (acc_ch < 0 && in_valid[k] && in_ready[k]) acc_ch = k;
      if (acc_ch >= 0) begin
        x = int'($signed(in_data[acc_ch*W +: W]));
        exp_q.push_back('{acc_ch, x + mhist[acc_ch][0] + mhist[acc_ch][1] + mhist[acc_ch][2], cyc});
        mhist[acc_ch][2] = mhist[acc_ch][1];
        mhist[acc_ch][1] = mhist[acc_ch][0];
        mhist[acc_ch][0] = x;
        rr_ptr = (acc_ch + 1) % NCH;
        inflight++;
      end
      if (flush)
        for (int c = 0; c < NCH; c++) for (int t = 0; t < 3; t++) mhist[c][t] = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int ch, input logic [W-1:0] v);
    int n;
    n = 0;
    in_valid[ch] = 1'b1;
    in_data[ch*W +: W] = v;
    @(negedge clk);
    while (!in_ready[ch] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with every channel requesting: in_ready must stay low
    in_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = '0;
    strict_lat = 1'b1;

    // Single channel ramp: 1,3,6,10,14
    for (int v = 1; v <= 5; v++) send(0, W'(v));
    step(3);
    chk("ch0_ramp", last_out[0], 14);

    // Extremes on channel 1
    pulse_flush();
    repeat (4) send(1, 16'h7FFF);
    step(3);
    chk("sat_pos", last_out[1], 131068);
    pulse_flush();
    repeat (4) send(1, 16'h8000);
    step(3);
    chk("sat_neg", last_out[1], -131072);

    // All channels continuously valid with constant i+1
    pulse_flush();
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = W'(i + 1);
    in_valid = '1;
    step(24);
    for (int i = 0; i < NCH; i++) chk("steady_sum", last_out[i], 4 * (i + 1));

    // Backpressure with both stages full
    strict_lat = 1'b0;
    out_ready = 1'b0;
    step(5);
    @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = '0;
    step(4);
    chk("bp_drain", exp_q.size(), 0);
    strict_lat = 1'b1;

    // Flush with one sample in flight on channel 2
    pulse_flush();
    send(2, 16'd10);
    send(2, 16'd20);
    send(2, 16'd30);
    send(2, 16'd40);
    pulse_flush();
    step(4);
    chk("flush_inflight", last_out[2], 100);
    send(2, 16'd7);
    step(4);
    chk("flush_new", last_out[2], 7);

    // Reset with two results in flight
    strict_lat = 1'b0;
    out_ready = 1'b0;
    send(0, 16'd3);
    send(1, 16'd4);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    in_data[2*W +: W] = 16'd5;
    in_data[3*W +: W] = 16'd9;
    in_valid = 4'b1100;
    @(negedge clk);
    chk("rst_first_grant", int'(in_ready), 4);
    @(posedge clk);
    #1;
    in_valid[2] = 1'b0;
    step(1);
    in_valid[3] = 1'b0;
    step(4);
    chk("rst_hist_ch2", last_out[2], 5);
    chk("rst_hist_ch3", last_out[3], 9);

    // Random traffic, backpressure and occasional flush
    for (int n = 0; n < 3000; n++) begin
      in_valid  = NCH'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(31) == 0);
      step(1);
    end
    in_valid = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    step(6);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
